// File: rtl/manchester_tx_scheduler.sv
// Round-robin scheduler that frames byte packets from NUM_REQ sources onto one Manchester encoder.
// Define MANCH_SCHED_CRC8_EN to append a CRC-8 (poly 0x07) byte after each frame's payload.
module manchester_tx_scheduler #(
  parameter int NUM_REQ      = 4,
  parameter int PREAMBLE_LEN = 2,
  parameter int MAX_LEN      = 64,
  parameter int GAP_CYCLES   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 enc_valid,
  output logic [7:0]           enc_data,
  input  logic                 enc_ready,
  output logic [2:0]           grant_id,
  output logic                 busy,
  output logic                 frame_done,
  output logic                 trunc
);

`ifdef MANCH_SCHED_CRC8_EN
  typedef enum logic [2:0] {S_IDLE, S_PREAMBLE, S_SFD, S_PAYLOAD, S_CRC, S_GAP} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_PREAMBLE, S_SFD, S_PAYLOAD, S_GAP} state_t;
`endif

  localparam logic [7:0] PRE_LAST = 8'(PREAMBLE_LEN - 1);
  localparam logic [7:0] LEN_LAST = 8'(MAX_LEN - 1);
  localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES - 1);
  localparam logic [2:0] REQ_LAST = 3'(NUM_REQ - 1);

  state_t     state_q, state_d;
  logic [2:0] grant_q, grant_d;
  logic [2:0] ptr_q, ptr_d;
  logic [7:0] cnt_q, cnt_d;
  logic       win_found;
  logic [2:0] win_id;
  logic       g_valid, g_last;
  logic [7:0] g_data;

`ifdef MANCH_SCHED_CRC8_EN
  logic [7:0] crc_q, crc_d;

  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int b = 0; b < 8; b++) begin
      c = c[7] ? ({c[6:0], 1'b0} ^ 8'h07) : {c[6:0], 1'b0};
    end
    return c;
  endfunction
`endif

  // First requesting index at or after the round-robin pointer wins.
  always_comb begin
    win_found = 1'b0;
    win_id    = 3'd0;
    for (int k = 0; k < NUM_REQ; k++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!win_found && (i == (int'(ptr_q) + k) % NUM_REQ) && req_valid[i]) begin
          win_found = 1'b1;
          win_id    = 3'(i);
        end
      end
    end
  end

  always_comb begin
    g_valid = 1'b0;
    g_last  = 1'b0;
    g_data  = 8'h00;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q == 3'(i)) begin
        g_valid = req_valid[i];
        g_last  = req_last[i];
        g_data  = req_data[8*i +: 8];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    enc_valid  = 1'b0;
    enc_data   = 8'h00;
    req_ready  = '0;
    frame_done = 1'b0;
    trunc      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          grant_d = win_id;
          ptr_d   = (win_id == REQ_LAST) ? 3'd0 : win_id + 3'd1;
          cnt_d   = 8'd0;
          state_d = S_PREAMBLE;
        end
      end
      S_PREAMBLE: begin
        enc_valid = 1'b1;
        enc_data  = 8'h55;
        if (enc_ready) begin
          if (cnt_q == PRE_LAST) begin
            cnt_d   = 8'd0;
            state_d = S_SFD;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      S_SFD: begin
        enc_valid = 1'b1;
        enc_data  = 8'hD5;
        if (enc_ready) begin
          cnt_d   = 8'd0;
          state_d = S_PAYLOAD;
        end
      end
      S_PAYLOAD: begin
        enc_valid = g_valid;
        enc_data  = g_data;
        for (int i = 0; i < NUM_REQ; i++) begin
          req_ready[i] = (grant_q == 3'(i)) && enc_ready;
        end
        if (g_valid && enc_ready) begin
          if (g_last || cnt_q == LEN_LAST) begin
            // A truncated frame ends exactly like a normal one; the remainder re-arbitrates later.
            trunc = !g_last;
            cnt_d = 8'd0;
`ifdef MANCH_SCHED_CRC8_EN
            state_d = S_CRC;
`else
            frame_done = 1'b1;
            state_d    = S_GAP;
`endif
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
`ifdef MANCH_SCHED_CRC8_EN
      S_CRC: begin
        enc_valid = 1'b1;
        enc_data  = crc_q;
        if (enc_ready) begin
          frame_done = 1'b1;
          cnt_d      = 8'd0;
          state_d    = S_GAP;
        end
      end
`endif
      S_GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d   = 8'd0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 8'd0;
      end
    endcase
  end

`ifdef MANCH_SCHED_CRC8_EN
  always_comb begin
    crc_d = crc_q;
    if (state_q == S_IDLE && win_found) begin
      crc_d = 8'h00;
    end else if (state_q == S_PAYLOAD && g_valid && enc_ready) begin
      crc_d = crc8_step(crc_q, g_data);
    end else begin
      crc_d = crc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      crc_q <= 8'h00;
    end else begin
      crc_q <= crc_d;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      grant_q <= 3'd0;
      ptr_q   <= 3'd0;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign grant_id = grant_q;
  assign busy     = (state_q != S_IDLE);

endmodule
